// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet transmit framer.
package eth_pkg;
  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_FCS  = 3'd4,
    ST_GAP  = 3'd5
  } eth_state_t;
endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 register; only built when ETH_TX_FCS_EN is defined.
module eth_crc32 import eth_pkg::*; (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  logic [31:0] r_crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      x = x[0] ? ((x >> 1) ^ CRC32_POLY) : (x >> 1);
    return x;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)      r_crc <= CRC32_INIT;
    else if (i_init) r_crc <= CRC32_INIT;
    else if (i_en)   r_crc <= crc_byte(r_crc, i_data);
  end

  assign o_crc = r_crc;
endmodule

// File: rtl/eth_tx_framer.sv
// Store-and-forward Ethernet TX framer: buffers a payload, then sends preamble, data, pad,
// optional FCS (macro ETH_TX_FCS_EN) and an inter-frame gap.
//
// state | meaning
// FILL  | accepting payload bytes into the buffer
// PRE   | 7 x preamble then SFD
// DATA  | stored payload bytes
// PAD   | zero bytes up to MIN_LEN
// FCS   | 4 complemented CRC bytes, LSB first
// GAP   | IFG idle cycles with o_tx_en low
module eth_tx_framer import eth_pkg::*; #(
  parameter int MAX_LEN = 1514,
  parameter int MIN_LEN = 60,
  parameter int IFG     = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_wdata,
  input  logic       i_wvalid,
  input  logic       i_wlast,
  output logic       o_wready,
  output logic [7:0] o_txd,
  output logic       o_tx_en,
  input  logic       i_tx_ready,
  output logic       o_drop,
  output logic       o_busy
);
  localparam int LW = $clog2(MAX_LEN + 2);
  localparam int AW = $clog2(MAX_LEN);
  localparam int GW = $clog2(IFG + 1);
`ifdef ETH_TX_FCS_EN
  localparam eth_state_t ST_END = ST_FCS;
`else
  localparam eth_state_t ST_END = ST_GAP;
`endif

  eth_state_t     r_state, w_state_nxt;
  logic [LW-1:0]  r_len, r_idx, w_idx_inc;
  logic [2:0]     r_pre;
  logic [GW-1:0]  r_gap;
  logic           r_drop_flag, r_drop, r_live;
  logic [7:0]     r_byte0, r_rd_data;
  logic [7:0]     r_mem [MAX_LEN];
  logic [AW-1:0]  w_addr;
  logic           w_accept, w_xfer, w_over, w_commit, w_discard, w_wr_en, w_rd_en;

  assign w_accept  = i_wvalid && o_wready;
  assign w_xfer    = o_tx_en && i_tx_ready;
  assign w_over    = (r_len == LW'(MAX_LEN));
  assign w_commit  = w_accept && i_wlast && !r_drop_flag && !w_over;
  assign w_discard = w_accept && i_wlast && (r_drop_flag || w_over);
  assign w_idx_inc = r_idx + 1'b1;

  // Byte 0 lives in a side register so DATA can start while the RAM fetches byte 1.
  assign w_wr_en = w_accept && !r_drop_flag && !w_over;
  assign w_rd_en = (r_state == ST_DATA) && w_xfer && (w_idx_inc < r_len);
  assign w_addr  = (r_state == ST_FILL) ? AW'(r_len) : AW'(w_idx_inc);

  always_ff @(posedge i_clk) begin
    if (w_wr_en)      r_mem[w_addr] <= i_wdata;
    else if (w_rd_en) r_rd_data     <= r_mem[w_addr];
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en && (r_len == '0)) r_byte0 <= i_wdata;
  end

`ifdef ETH_TX_FCS_EN
  logic [31:0] w_crc;
  logic [1:0]  r_fcs;
  logic [7:0]  w_fcs_byte;

  eth_crc32 u_crc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_init (r_state == ST_PRE),
    .i_en   (w_xfer && ((r_state == ST_DATA) || (r_state == ST_PAD))),
    .i_data (o_txd),
    .o_crc  (w_crc)
  );

  assign w_fcs_byte = ~w_crc[{r_fcs, 3'b000} +: 8];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                            r_fcs <= '0;
    else if (r_state != ST_FCS)            r_fcs <= '0;
    else if (w_xfer)                       r_fcs <= r_fcs + 1'b1;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_commit) w_state_nxt = ST_PRE;
      ST_PRE:  if (w_xfer && (r_pre == 3'd7)) w_state_nxt = ST_DATA;
      ST_DATA: if (w_xfer && (w_idx_inc == r_len))
                 w_state_nxt = (w_idx_inc < LW'(MIN_LEN)) ? ST_PAD : ST_END;
      ST_PAD:  if (w_xfer && (w_idx_inc == LW'(MIN_LEN))) w_state_nxt = ST_END;
`ifdef ETH_TX_FCS_EN
      ST_FCS:  if (w_xfer && (r_fcs == 2'd3)) w_state_nxt = ST_GAP;
`endif
      ST_GAP:  if (r_gap == '0) w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_pre       <= '0;
      r_gap       <= '0;
      r_drop_flag <= 1'b0;
      r_drop      <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_drop <= w_discard;
      case (r_state)
        ST_FILL: begin
          r_idx <= '0;
          r_pre <= '0;
          if (w_discard) begin
            r_len       <= '0;
            r_drop_flag <= 1'b0;
          end else if (w_accept && !r_drop_flag) begin
            r_len <= r_len + 1'b1;
            if (w_over) r_drop_flag <= 1'b1;
          end
        end
        ST_PRE:  if (w_xfer) r_pre <= r_pre + 1'b1;
        ST_DATA, ST_PAD: if (w_xfer) r_idx <= w_idx_inc;
        ST_GAP: begin
          if (r_gap != '0) r_gap <= r_gap - 1'b1;
          else             r_len <= '0;
        end
        default: ;
      endcase
      if ((r_state != ST_GAP) && (w_state_nxt == ST_GAP)) r_gap <= GW'(IFG - 1);
    end
  end

  always_comb begin
    o_txd = 8'h00;
    case (r_state)
      ST_PRE:  o_txd = (r_pre == 3'd7) ? ETH_SFD : ETH_PREAMBLE;
      ST_DATA: o_txd = (r_idx == '0) ? r_byte0 : r_rd_data;
`ifdef ETH_TX_FCS_EN
      ST_FCS:  o_txd = w_fcs_byte;
`endif
      default: o_txd = 8'h00;
    endcase
  end

  assign o_tx_en  = (r_state == ST_PRE) || (r_state == ST_DATA) ||
                    (r_state == ST_PAD) || (r_state == ST_FCS);
  assign o_wready = (r_state == ST_FILL) && r_live;
  assign o_busy   = (r_state != ST_FILL);
  assign o_drop   = r_drop;
endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1514, maximum accepted payload bytes per frame (FCS excluded).
REQ-002 SHALL have parameter MIN_LEN, default 60, minimum transmitted bytes before FCS; shorter frames are zero-padded.
REQ-003 SHALL have parameter IFG, default 12, idle cycles with o_tx_en low after each frame.
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-low.
REQ-006 i_wdata  in  8  payload byte from protocol stage.
REQ-007 i_wvalid  in  1  i_wdata valid; byte accepted when i_wvalid && o_wready.
REQ-008 i_wlast  in  1  qualifies accepted byte as last of frame.
REQ-009 o_wready  out  1  framer can accept a payload byte.
REQ-010 o_txd  out  8  byte to MAC/PHY.
REQ-011 o_tx_en  out  1  o_txd valid, high from first preamble byte to last FCS byte inclusive.
REQ-012 i_tx_ready  in  1  MAC takes o_txd when o_tx_en && i_tx_ready.
REQ-013 o_drop  out  1  one-cycle pulse: oversize frame discarded.
REQ-014 o_busy  out  1  high in any state except FILL.

Function
REQ-015 SHALL implement states FILL, PRE, DATA, PAD, FCS, GAP.
REQ-016 FILL: o_wready=1; accepted bytes written to MAX_LEN x 8 buffer at length counter, counter +1.
REQ-017 Accepted byte with i_wlast in FILL SHALL commit the frame and move to PRE next cycle; o_wready=0 outside FILL.
REQ-018 Accepting byte MAX_LEN+1 SHALL set a drop flag; further bytes accepted and discarded until i_wlast, then o_drop=1 for one cycle, counter cleared, stay in FILL, no transmission.
REQ-019 PRE SHALL emit 7 x 0x55 then 0xD5, then DATA.
REQ-020 DATA SHALL emit stored bytes in order; buffer read latency hidden, no bubbles while i_tx_ready=1.
REQ-021 After last stored byte: if count < MIN_LEN go PAD emitting 0x00 until MIN_LEN bytes sent, else go FCS (or GAP per REQ-030).
REQ-022 While o_tx_en=1 and i_tx_ready=0, o_txd and state SHALL hold; byte counters advance only on transfer.
REQ-023 GAP SHALL hold o_tx_en=0 for exactly IFG cycles, then FILL with counter 0.
REQ-024 o_tx_en SHALL not drop between PRE and end of FCS regardless of i_tx_ready.
REQ-025 Length counter width SHALL be clog2(MAX_LEN+2); no wrap possible.

Reset
REQ-026 i_rst low SHALL asynchronously force FILL, counters 0, drop flag 0, o_tx_en=0, o_txd=0x00, o_drop=0, o_busy=0.
REQ-027 o_wready SHALL be 0 while i_rst low and 1 from first clock after release.
REQ-028 Reset mid-frame (fill or transmit) SHALL discard the frame; buffer contents need not be cleared.

Configuration
REQ-029 Macro ETH_TX_FCS_EN defined: CRC-32 (poly 0xEDB88320 reflected, init 0xFFFFFFFF) over data+pad, complemented, sent in FCS state as 4 bytes, LSB first.
REQ-030 ETH_TX_FCS_EN undefined: no CRC logic, FCS state unreachable, PAD/DATA go directly to GAP.

Structure
REQ-031 Package eth_pkg SHALL hold ETH_PREAMBLE 0x55, ETH_SFD 0xD5, CRC32_POLY, CRC32_INIT, CRC32_RESIDUE 0xDEBB20E3 and the state enumeration.
REQ-032 CRC byte update SHALL be sub-module eth_crc32 (init, enable, byte in, 32-bit state out), instantiated only under ETH_TX_FCS_EN.
REQ-033 Buffer SHALL be inferred single-port synchronous RAM; writes only in FILL, reads only in DATA.

Verification
REQ-034 64-byte frame 0x00..0x3F, i_tx_ready=1, FCS on -> 7x55, D5, 0x00..0x3F, 4 FCS bytes; o_tx_en high 76 cycles, then 12 low.
REQ-035 1-byte frame 0xAA -> D5, AA, 59 x 00, 4 FCS; o_tx_en high 72 cycles (68 with FCS off).
REQ-036 Any frame, FCS on -> reflected CRC-32 over emitted data+pad+FCS equals residue 0xDEBB20E3.
REQ-037 REQ-034 with i_tx_ready toggling every cycle -> identical byte sequence, o_txd stable during stalls, o_tx_en never low mid-frame.
REQ-038 1515-byte frame -> o_drop one pulse after i_wlast byte, o_tx_en stays 0; following 64-byte frame transmitted per REQ-034.
REQ-039 i_rst low during DATA byte 10 -> o_tx_en 0 same cycle; after release o_wready=1, next frame transmitted correctly.
